// File: rtl/seq_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per clock,
// LSB chunk first, through a registered carry. Results and flags load on completion.
module seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             state_dbg
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Handshake: start is taken on a rising edge only while idle (busy = 0);
    // done pulses for exactly one cycle after the result registers load.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx;
    logic               cy;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   out_r;
    logic               carry_r;
    logic               overflow_r;
    logic               done_r;

    logic [CHUNK:0]     sum_ext;
    logic               cin_msb;
    logic               last;
    logic [WIDTH-1:0]   acc_next;

    // Operands shift right each cycle so the active chunk is always the low
    // CHUNK bits; the sum enters the accumulator from the top.
    always_comb begin
        sum_ext  = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + (CHUNK+1)'(cy);
        cin_msb  = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ sum_ext[CHUNK-1];
        acc_next = (acc >> CHUNK) | (WIDTH'(sum_ext[CHUNK-1:0]) << (WIDTH - CHUNK));
        last     = (idx == IDX_W'(N - 1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            cy         <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            acc        <= '0;
            out_r      <= '0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    op_a <= a;
                    op_b <= sub ? ~b : b;
                    cy   <= sub;
                    idx  <= '0;
                    acc  <= '0;
                end
            end else begin
                op_a <= op_a >> CHUNK;
                op_b <= op_b >> CHUNK;
                cy   <= sum_ext[CHUNK];
                idx  <= idx + IDX_W'(1);
                acc  <= acc_next;
                if (last) begin
                    out_r      <= acc_next;
                    carry_r    <= sum_ext[CHUNK];
                    overflow_r <= cin_msb ^ sum_ext[CHUNK];
                    done_r     <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_r;
    assign out       = out_r;
    assign carry     = carry_r;
    assign overflow  = overflow_r;
    assign zero      = (out_r == '0);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: scoreboard with a decoupled monitor, directed cases,
// random operations, handshake, abort and two alternative parameter sets.
module tb_seq_adder;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry, overflow, zero, state_dbg;
    logic [W-1:0] out;

    logic        start8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, out8;
    logic        busy8, done8, carry8, overflow8, zero8, state8;

    logic        start32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, out32;
    logic        busy32, done32, carry32, overflow32, zero32, state32;

    seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clock(clk), .reset_n(reset_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .out(out), .carry(carry), .overflow(overflow),
        .zero(zero), .state_dbg(state_dbg)
    );

    seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clock(clk), .reset_n(reset_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .out(out8), .carry(carry8), .overflow(overflow8),
        .zero(zero8), .state_dbg(state8)
    );

    seq_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clock(clk), .reset_n(reset_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .out(out32), .carry(carry32), .overflow(overflow32),
        .zero(zero32), .state_dbg(state32)
    );

    int errors = 0;
    int checks = 0;
    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Scoreboard entries are {out, carry, overflow}.
    logic [W+1:0] exp_q[$];
    int           lat_q[$];
    logic [W-1:0] last_out = '0;
    logic [W+1:0] mon_e;
    int           mon_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        int ux, uy, sx, sy, r, sr;
        logic [W-1:0] res;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r  = ux - uy;
            c  = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = ux + uy;
            c  = (r > (1 << W) - 1);
            sr = sx + sy;
        end
        res = r[W-1:0];
        v   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return {res, c, v};
    endfunction

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_acc = lat_q.pop_front();
                    check("out", out, mon_e[W+1:2]);
                    check("carry", carry, mon_e[1]);
                    check("overflow", overflow, mon_e[0]);
                    check("zero", zero, mon_e[W+1:2] == '0);
                    check("latency", cycle_cnt - mon_acc, N);
                    check("busy_in_done", busy, 0);
                    last_out = mon_e[W+1:2];
                end
            end else begin
                check("out_hold", out, last_out);
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (busy !== 1'b0 && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) check("idle_timeout", busy, 0);
    endtask

    // Drives one request at a negedge where the DUT is idle; when exp_v is
    // given (use_exp) it is the expected result, otherwise the model supplies it.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input bit use_exp, input logic [W+1:0] exp_v);
        wait_idle();
        a = x;
        b = y;
        sub = s;
        start = 1'b1;
        exp_q.push_back(use_exp ? exp_v : model(x, y, s));
        @(posedge clk);
        #1;
        lat_q.push_back(cycle_cnt);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int acc_cycle;

        // Reset held with start pulsed.
        start = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out", out, 0);
        check("rst_zero", zero, 1);
        check("rst_carry", carry, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", state_dbg, 0);
        check("rst_zero8", zero8, 1);
        check("rst_out32", out32, 0);
        start = 1'b0;
        reset_n = 1'b1;

        // Directed cases with literal expectations {out, carry, overflow}.
        issue(16'h0000, 16'hFFFF, 1'b0, 1, {16'hFFFF, 1'b0, 1'b0});
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1, {16'hFFFE, 1'b1, 1'b0});
        issue(16'hAAAA, 16'h5555, 1'b0, 1, {16'hFFFF, 1'b0, 1'b0});
        issue(16'h3CC3, 16'h0FF0, 1'b0, 1, {16'h4CB3, 1'b0, 1'b0});
        issue(16'h1234, 16'h9876, 1'b0, 1, {16'hAAAA, 1'b0, 1'b0});
        issue(16'h7FFF, 16'hFFFF, 1'b1, 1, {16'h8000, 1'b0, 1'b1});
        issue(16'h1234, 16'h1234, 1'b1, 1, {16'h0000, 1'b1, 1'b0});
        issue(16'h0000, 16'h0001, 1'b1, 1, {16'hFFFF, 1'b0, 1'b0});
        drain();

        // Start during RUN is ignored; restart in the done cycle is taken.
        issue(16'h0001, 16'h0001, 1'b0, 1, {16'h0002, 1'b0, 1'b0});
        @(negedge clk);
        a = 16'h7000;
        b = 16'h7000;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        issue(16'h7000, 16'h7000, 1'b0, 1, {16'hE000, 1'b0, 1'b1});
        drain();

        // Random operations with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom), 0, '0);
        end
        drain();

        // Abort mid-operation.
        wait_idle();
        a = 16'hFFFF;
        b = 16'h0001;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        last_out = '0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out", out, 0);
        check("abort_done", done, 0);
        check("abort_zero", zero, 1);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(16'h0F0F, 16'h0101, 1'b0, 1, {16'h1010, 1'b0, 1'b0});
        drain();

        // WIDTH=8, CHUNK=8: single RUN cycle.
        @(negedge clk);
        a8 = 8'hFF;
        b8 = 8'h01;
        sub8 = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start8 = 1'b0;
        check("w8_busy", busy8, 1);
        check("w8_done_early", done8, 0);
        @(negedge clk);
        check("w8_done", done8, 1);
        check("w8_out", out8, 8'h00);
        check("w8_carry", carry8, 1);
        check("w8_zero", zero8, 1);
        check("w8_overflow", overflow8, 0);

        // WIDTH=32, CHUNK=8: four RUN cycles.
        @(negedge clk);
        a32 = 32'hFFFF_FFFF;
        b32 = 32'h0000_0001;
        sub32 = 1'b0;
        start32 = 1'b1;
        @(posedge clk);
        #1;
        acc_cycle = cycle_cnt;
        @(negedge clk);
        start32 = 1'b0;
        guard = 0;
        while (done32 !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        check("w32_latency", cycle_cnt - acc_cycle, 4);
        check("w32_out", out32, 32'h0);
        check("w32_carry", carry32, 1);
        check("w32_zero", zero32, 1);
        @(negedge clk);
        check("w32_done_pulse", done32, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
